// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-token codes, ctrl encoding, alignment FSM states
// and the video-character decode used by both ends of the link.
package tmds_pkg;

  localparam logic [9:0] TOKEN_C00 = 10'h354;
  localparam logic [9:0] TOKEN_C01 = 10'h0AB;
  localparam logic [9:0] TOKEN_C10 = 10'h154;
  localparam logic [9:0] TOKEN_C11 = 10'h2AB;

  localparam logic [1:0] CTRL_00 = 2'b00;
  localparam logic [1:0] CTRL_01 = 2'b01;
  localparam logic [1:0] CTRL_10 = 2'b10;
  localparam logic [1:0] CTRL_11 = 2'b11;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } align_state_e;

  // Undo the optional inversion (q[9]) and the XOR/XNOR chain selected by q[8].
  function automatic logic [7:0] tmds_decode_data(input logic [9:0] q);
    logic [7:0] b;
    logic [7:0] d;
    b    = q[9] ? ~q[7:0] : q[7:0];
    d    = 8'h00;
    d[0] = b[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = q[8] ? (b[i] ^ b[i-1]) : ~(b[i] ^ b[i-1]);
    end
    return d;
  endfunction

endpackage

// File: rtl/tmds_word_decode.sv
// Combinational decode of one aligned 10-bit TMDS character into either a
// control token ({c1,c0}) or an 8-bit video byte.
module tmds_word_decode
  import tmds_pkg::*;
(
  input  logic [9:0] word,
  output logic [7:0] data,
  output logic [1:0] ctrl,
  output logic       is_ctrl
);

  // Token match first; any other code is treated as a video character
  always_comb begin
    data    = tmds_decode_data(word);
    ctrl    = CTRL_00;
    is_ctrl = 1'b0;
    case (word)
      TOKEN_C00: begin ctrl = CTRL_00; is_ctrl = 1'b1; end
      TOKEN_C01: begin ctrl = CTRL_01; is_ctrl = 1'b1; end
      TOKEN_C10: begin ctrl = CTRL_10; is_ctrl = 1'b1; end
      TOKEN_C11: begin ctrl = CTRL_11; is_ctrl = 1'b1; end
      default:   begin ctrl = CTRL_00; is_ctrl = 1'b0; end
    endcase
  end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS receive channel: finds the character boundary by hunting for runs
// of control tokens, then decodes aligned characters to video data or ctrl.
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int TOKEN_RUN = 8,
  parameter int TIMEOUT   = 2048
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] tmds_word,
  output logic [7:0] data,
  output logic [1:0] ctrl,
  output logic       de,
  output logic       locked,
  output logic [3:0] offset
);

  localparam int               RUN_W       = $clog2(TOKEN_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_FULL    = RUN_W'(TOKEN_RUN);
  localparam logic [RUN_W-1:0] RUN_ZERO    = RUN_W'(32'd0);
  localparam logic [RUN_W-1:0] RUN_ONE     = RUN_W'(32'd1);
  localparam logic [15:0]      TIMER_LIMIT = 16'(TIMEOUT);

  logic [9:0]       prev_word_r;
  logic [9:0]       aligned_r;
  logic [19:0]      window_s;
  logic [9:0]       aligned_s;
  logic [7:0]       dec_data_s;
  logic [1:0]       dec_ctrl_s;
  logic             dec_is_ctrl_s;
  logic [RUN_W-1:0] run_r;
  logic [RUN_W-1:0] run_next_s;
  logic [15:0]      timer_r;
  logic [15:0]      timer_inc_s;
  logic             run_done_s;
  logic             timeout_s;
  logic             lock_next_s;
  logic [3:0]       offset_r;
  logic [3:0]       offset_step_s;
  align_state_e     state_r;
  logic [7:0]       data_r;
  logic [1:0]       ctrl_r;
  logic             de_r;
  logic             locked_r;

  // Bit 0 of the window is the earliest bit on the wire.
  assign window_s  = {tmds_word, prev_word_r};
  assign aligned_s = window_s[offset_r +: 10];

  tmds_word_decode u_word_decode (
    .word    (aligned_r),
    .data    (dec_data_s),
    .ctrl    (dec_ctrl_s),
    .is_ctrl (dec_is_ctrl_s)
  );

  // Next run count, saturating word timer, offset step and next lock status
  always_comb begin
    run_next_s    = RUN_ZERO;
    timer_inc_s   = timer_r;
    offset_step_s = 4'd0;
    lock_next_s   = 1'b0;
    if (dec_is_ctrl_s) begin
      if (run_r == RUN_FULL) begin
        run_next_s = run_r;
      end else begin
        run_next_s = run_r + RUN_ONE;
      end
    end else begin
      run_next_s = RUN_ZERO;
    end
    if (timer_r == 16'hFFFF) begin
      timer_inc_s = timer_r;
    end else begin
      timer_inc_s = timer_r + 16'd1;
    end
    if (offset_r >= 4'd9) begin
      offset_step_s = 4'd0;
    end else begin
      offset_step_s = offset_r + 4'd1;
    end
    // A completed run outranks a simultaneous timeout.
    if (run_done_s) begin
      lock_next_s = 1'b1;
    end else if ((state_r == ST_LOCKED) && !timeout_s) begin
      lock_next_s = 1'b1;
    end else begin
      lock_next_s = 1'b0;
    end
  end

  assign run_done_s = (run_next_s == RUN_FULL);
  assign timeout_s  = (timer_inc_s >= TIMER_LIMIT);

  // Alignment front end: previous raw word and the selected character
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_word_r <= 10'd0;
      aligned_r   <= 10'd0;
    end else begin
      prev_word_r <= tmds_word;
      aligned_r   <= aligned_s;
    end
  end

  // Alignment FSM with run/timer bookkeeping and lock-gated output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_SEARCH;
      offset_r <= 4'd0;
      run_r    <= RUN_ZERO;
      timer_r  <= 16'd0;
      data_r   <= 8'h00;
      ctrl_r   <= CTRL_00;
      de_r     <= 1'b0;
      locked_r <= 1'b0;
    end else begin
      run_r   <= run_next_s;
      timer_r <= timer_inc_s;
      case (state_r)
        ST_SEARCH: begin
          if (run_done_s) begin
            state_r <= ST_LOCKED;
            timer_r <= 16'd0;
          end else if (timeout_s) begin
            offset_r <= offset_step_s;
            run_r    <= RUN_ZERO;
            timer_r  <= 16'd0;
          end else begin
            state_r <= ST_SEARCH;
          end
        end
        ST_LOCKED: begin
          if (run_done_s) begin
            timer_r <= 16'd0;
          end else if (timeout_s) begin
            state_r <= ST_SEARCH;
            run_r   <= RUN_ZERO;
            timer_r <= 16'd0;
          end else begin
            state_r <= ST_LOCKED;
          end
        end
        default: begin
          state_r <= ST_SEARCH;
          run_r   <= RUN_ZERO;
          timer_r <= 16'd0;
        end
      endcase
      locked_r <= lock_next_s;
      if (lock_next_s) begin
        de_r   <= ~dec_is_ctrl_s;
        data_r <= dec_is_ctrl_s ? 8'h00 : dec_data_s;
        ctrl_r <= dec_is_ctrl_s ? dec_ctrl_s : CTRL_00;
      end else begin
        de_r   <= 1'b0;
        data_r <= 8'h00;
        ctrl_r <= CTRL_00;
      end
    end
  end

  assign data   = data_r;
  assign ctrl   = ctrl_r;
  assign de     = de_r;
  assign locked = locked_r;
  assign offset = offset_r;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder: queued expectations are popped by a
// monitor while locked, plus direct checks of lock timing and offset stepping.
module tb_tmds_channel_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] tmds_word;
  logic [7:0] data;
  logic [1:0] ctrl;
  logic       de;
  logic       locked;
  logic [3:0] offset;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       de;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic sb_on = 1'b0;

  always #5 clk = ~clk;

  tmds_channel_decoder dut (
    .clk       (clk),
    .reset     (reset),
    .tmds_word (tmds_word),
    .data      (data),
    .ctrl      (ctrl),
    .de        (de),
    .locked    (locked),
    .offset    (offset)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (step %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic [1:0] c, input logic e);
    exp_t x;
    x.data = d;
    x.ctrl = c;
    x.de   = e;
    exp_q.push_back(x);
  endtask

  task automatic step(input logic [9:0] w);
    tmds_word = w;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [9:0] line_char(input int j);
    int p;
    p = j % 1650;
    if (p < 1280) return 10'h100;
    case ((p - 1280) % 4)
      0:       return 10'h354;
      1:       return 10'h0AB;
      2:       return 10'h154;
      default: return 10'h2AB;
    endcase
  endfunction

  // Scoreboard monitor: every locked output cycle consumes one expectation
  always @(negedge clk) begin
    if (sb_on && (locked === 1'b1)) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_de", {31'd0, de}, {31'd0, mon_e.de});
        check("sb_data", {24'd0, data}, {24'd0, mon_e.data});
        check("sb_ctrl", {30'd0, ctrl}, {30'd0, mon_e.ctrl});
      end
    end
  end

  initial begin
    int steps[$];
    int last_off;
    int lock_cyc;
    int post_lock;
    int ctrl_errs;
    int data_errs;
    int tok_seen;
    int lost;
    int lock_errs;
    logic have_prev;
    logic [1:0] exp_ctrl;
    logic [9:0] prev_char;
    logic [9:0] cur_char;

    // Reset held with random input, then 5 data words.
    reset     = 1'b1;
    tmds_word = 10'd0;
    #2;
    for (int i = 0; i < 4; i++) begin
      tmds_word = 10'($urandom);
      @(posedge clk);
      #1;
      check("reset_outs", {17'd0, data, ctrl, de, locked, offset}, 32'd0);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(10'h100);
      check("post_reset_outs", {17'd0, data, ctrl, de, locked, offset}, 32'd0);
    end

    // Aligned lock, data decode, loss of lock and relock.
    cyc   = 0;
    sb_on = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      if (n >= 8) push_exp(8'h00, 2'b00, 1'b0);
      step(10'h354);
      if (n == 9) check("lock_early", {31'd0, locked}, 32'd0);
      if (n == 10) begin
        check("lock_rise", {31'd0, locked}, 32'd1);
        check("lock_offset", {28'd0, offset}, 32'd0);
      end
    end
    push_exp(8'h00, 2'b00, 1'b1);
    step(10'h100);
    push_exp(8'hFE, 2'b00, 1'b1);
    step(10'h2FF);
    for (int n = 15; n <= 2066; n++) begin
      if (n <= 2059) push_exp(8'h00, 2'b00, 1'b1);
      step(10'h100);
      if (n == 2061) check("loss_hold", {31'd0, locked}, 32'd1);
      if (n == 2062) begin
        check("loss_fall", {31'd0, locked}, 32'd0);
        check("loss_offset", {28'd0, offset}, 32'd0);
        check("loss_outs", {21'd0, data, ctrl, de}, 32'd0);
      end
    end
    sb_on = 1'b0;
    check("sb_drain", exp_q.size(), 32'd0);
    for (int n = 2067; n <= 2076; n++) begin
      step(10'h354);
      if (n == 2075) check("relock_early", {31'd0, locked}, 32'd1 - 32'd1);
      if (n == 2076) begin
        check("relock", {31'd0, locked}, 32'd1);
        check("relock_offset", {28'd0, offset}, 32'd0);
      end
    end

    // Stream delayed by 3 bits: offset must step 0->1->2->3 and then lock.
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    cyc       = 0;
    last_off  = 0;
    lock_cyc  = 0;
    post_lock = 0;
    ctrl_errs = 0;
    data_errs = 0;
    tok_seen  = 0;
    lost      = 0;
    have_prev = 1'b0;
    exp_ctrl  = 2'b00;
    prev_char = 10'd0;
    for (int j = 0; j < 13000 && post_lock < 3300; j++) begin
      cur_char = line_char(j);
      step({cur_char[6:0], prev_char[9:7]});
      prev_char = cur_char;
      if (int'(offset) != last_off) begin
        steps.push_back(cyc);
        last_off = int'(offset);
      end
      if (lock_cyc != 0) begin
        post_lock++;
        if (locked !== 1'b1) lost++;
      end else if (locked === 1'b1) begin
        lock_cyc = cyc;
        check("mis_lock_offset", {28'd0, offset}, 32'd3);
      end
      if (locked === 1'b1) begin
        if (have_prev && (de === 1'b0)) begin
          tok_seen++;
          if (ctrl !== exp_ctrl) ctrl_errs++;
        end else if (have_prev && (data !== 8'h00)) begin
          data_errs++;
        end
        have_prev = 1'b1;
        exp_ctrl  = de ? 2'b00 : ctrl + 2'd1;
      end
    end
    check("mis_locked", {31'd0, (lock_cyc != 0)}, 32'd1);
    check("mis_lock_after_steps", {31'd0, (lock_cyc > 6144)}, 32'd1);
    check("mis_step_count", steps.size(), 32'd3);
    if (steps.size() >= 3) begin
      check("mis_step1", steps[0], 32'd2048);
      check("mis_step2", steps[1], 32'd4096);
      check("mis_step3", steps[2], 32'd6144);
    end
    check("mis_ctrl_seq_errs", ctrl_errs, 32'd0);
    check("mis_data_errs", data_errs, 32'd0);
    check("mis_tokens_seen", {31'd0, (tok_seen >= 300)}, 32'd1);
    check("mis_lock_lost", lost, 32'd0);

    // Reset while locked at offset 3 clears without a clock edge.
    check("pre_reset_locked", {31'd0, locked}, 32'd1);
    check("pre_reset_offset", {28'd0, offset}, 32'd3);
    reset = 1'b1;
    #1;
    check("async_reset_locked", {31'd0, locked}, 32'd0);
    check("async_reset_offset", {28'd0, offset}, 32'd0);
    check("async_reset_outs", {21'd0, data, ctrl, de}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Bursts of 7 tokens + 1 data word never lock; offset steps at word 2048.
    cyc       = 0;
    lock_errs = 0;
    last_off  = 0;
    steps.delete();
    for (int n = 1; n <= 3000; n++) begin
      step((n % 8 == 0) ? 10'h100 : 10'h354);
      if ((locked !== 1'b0) || (de !== 1'b0) || (data !== 8'h00) || (ctrl !== 2'b00)) lock_errs++;
      if (int'(offset) != last_off) begin
        steps.push_back(cyc);
        last_off = int'(offset);
      end
    end
    check("short_no_lock", lock_errs, 32'd0);
    check("short_step_count", steps.size(), 32'd1);
    if (steps.size() >= 1) check("short_step_at", steps[0], 32'd2048);
    check("short_offset", {28'd0, offset}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
